// File: rtl/lsf_theta_scheduler.sv
// -----------------------------------------------------------------------------
// lsf_theta_scheduler
//
// Purpose:
//   Accepts one hit (local x, local y, r offset) at a time and sweeps it across
//   NTHETA theta bins, one bin per cycle. Each issued bin drives the sin/cos LUT
//   address. The captured hit follows the LUT read latency so that it reaches
//   the r-bin datapath in step with the LUT data. A theta tag follows
//   the whole LUT + 2-cycle r-bin datapath latency. Downstream backpressure
//   (stall) freezes the sweep without skipping or repeating a bin. At the last
//   bin a new hit can be taken with no bubble.
//
// Parameters:
//   NTHETA   theta bins per hit (power of 2, 4..256)
//   W_THETA  log2(NTHETA)
//   W_X/W_Y  hit local x / y widths
//   W_r      r offset width
//   LUT_LAT  sin/cos LUT read latency, 0..3 cycles
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_vld / in_ready     hit handshake; accepted when both are high
//   in_localx/y/r_offset  hit payload
//   stall                 downstream backpressure, freezes the sweep
//   lut_addr              sin/cos LUT address (current theta index)
//   dp_hit_vld, dp_*      datapath hit valid and payload, aligned to LUT data;
//                         payload reads 0 whenever dp_hit_vld is 0
//   theta_tag             theta index aligned with the r-bin datapath output
//   busy                  sweeping, or issued bins still in flight
//   sweep_done            one-cycle pulse when the last bin of a hit issues
//   hit_count             (only with LSF_SCHED_HITCNT_EN) saturating 16-bit
//                         count of accepted hits
//
// Build option:
//   Define LSF_SCHED_HITCNT_EN to add the hit_count output and its counter.
// -----------------------------------------------------------------------------
module lsf_theta_scheduler #(
  parameter int NTHETA  = 128,
  parameter int W_THETA = 7,
  parameter int W_X     = 14,
  parameter int W_Y     = 14,
  parameter int W_r     = 22,
  parameter int LUT_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  output logic               in_ready,
  input  logic [W_X-1:0]     in_localx,
  input  logic [W_Y-1:0]     in_localy,
  input  logic [W_r-1:0]     in_r_offset,
  input  logic               stall,
  output logic [W_THETA-1:0] lut_addr,
  output logic               dp_hit_vld,
  output logic [W_X-1:0]     dp_localx,
  output logic [W_Y-1:0]     dp_localy,
  output logic [W_r-1:0]     dp_r_offset,
  output logic [W_THETA-1:0] theta_tag,
  output logic               busy,
`ifdef LSF_SCHED_HITCNT_EN
  output logic [15:0]        hit_count,
`endif
  output logic               sweep_done
);

  // Issue strobe and theta index both travel through the LUT plus the 2-cycle
  // r-bin datapath.
  localparam int DEPTH = LUT_LAT + 2;
  localparam logic [W_THETA-1:0] LAST_THETA = W_THETA'(NTHETA - 1);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [W_THETA-1:0] r_cnt, w_cnt_nxt;
  logic [W_X-1:0]     r_x;
  logic [W_Y-1:0]     r_y;
  logic [W_r-1:0]     r_r;

  logic               w_issue;
  logic               w_accept;
  logic               w_last;

  logic [DEPTH:1]     r_vld_dly;
  logic [W_THETA-1:0] r_theta_dly [1:DEPTH];

  // ---------------------------------------------------------------------------
  // State, counter and hit capture
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_r     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_x <= in_localx;
        r_y <= in_localy;
        r_r <= in_r_offset;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, handshake and issue strobe
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; without it a path
  // that skips an assignment would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_issue     = 1'b0;
    in_ready    = 1'b0;
    sweep_done  = 1'b0;
    w_last      = (r_cnt == LAST_THETA);

    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
      end
      SWEEP: begin
        if (!stall) begin
          w_issue = 1'b1;
          if (w_last) begin
            sweep_done = 1'b1;
            in_ready   = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // While reset is asserted nothing is offered upstream or issued downstream;
    // in_ready therefore rises in the first cycle after release.
    if (!rst_n) begin
      in_ready   = 1'b0;
      w_issue    = 1'b0;
      sweep_done = 1'b0;
    end

    w_accept = in_vld && in_ready;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_cnt_nxt   = '0;
          w_state_nxt = SWEEP;
        end
      end
      SWEEP: begin
        if (w_issue) begin
          if (w_last) begin
            // Back-to-back reload keeps the sweep going with no bubble.
            w_cnt_nxt   = '0;
            w_state_nxt = w_accept ? SWEEP : IDLE;
          end else begin
            w_cnt_nxt = r_cnt + W_THETA'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // The counter holds during stall, so the LUT sees the same address until
  // the bin is actually issued.
  assign lut_addr = r_cnt;

  // ---------------------------------------------------------------------------
  // Strobe / theta delay line (LUT latency + r-bin datapath)
  // ---------------------------------------------------------------------------
  // NOTE: these small delay lines are reset explicitly; a mid-sweep reset must
  // flush in-flight strobes so no dp_hit_vld or stale tag escapes afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_dly <= '0;
      for (int k = 1; k <= DEPTH; k++) r_theta_dly[k] <= '0;
    end else begin
      r_vld_dly      <= {r_vld_dly[DEPTH-1:1], w_issue};
      r_theta_dly[1] <= lut_addr;
      for (int k = 2; k <= DEPTH; k++) r_theta_dly[k] <= r_theta_dly[k-1];
    end
  end

  assign theta_tag = r_theta_dly[DEPTH];
  assign busy      = (r_state == SWEEP) || (|r_vld_dly);

  // ---------------------------------------------------------------------------
  // Datapath hit alignment with LUT data
  // ---------------------------------------------------------------------------
  generate
    if (LUT_LAT == 0) begin : g_nodly
      assign dp_hit_vld  = w_issue;
      assign dp_localx   = w_issue ? r_x : '0;
      assign dp_localy   = w_issue ? r_y : '0;
      assign dp_r_offset = w_issue ? r_r : '0;
    end else begin : g_dly
      logic [W_X-1:0] r_x_dly [1:LUT_LAT];
      logic [W_Y-1:0] r_y_dly [1:LUT_LAT];
      logic [W_r-1:0] r_r_dly [1:LUT_LAT];

      // Payload is zeroed on entry when not issued, so it reads 0 at the
      // output whenever the matching valid is low.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 1; k <= LUT_LAT; k++) begin
            r_x_dly[k] <= '0;
            r_y_dly[k] <= '0;
            r_r_dly[k] <= '0;
          end
        end else begin
          r_x_dly[1] <= w_issue ? r_x : '0;
          r_y_dly[1] <= w_issue ? r_y : '0;
          r_r_dly[1] <= w_issue ? r_r : '0;
          for (int k = 2; k <= LUT_LAT; k++) begin
            r_x_dly[k] <= r_x_dly[k-1];
            r_y_dly[k] <= r_y_dly[k-1];
            r_r_dly[k] <= r_r_dly[k-1];
          end
        end
      end

      assign dp_hit_vld  = r_vld_dly[LUT_LAT];
      assign dp_localx   = r_x_dly[LUT_LAT];
      assign dp_localy   = r_y_dly[LUT_LAT];
      assign dp_r_offset = r_r_dly[LUT_LAT];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Optional accepted-hit counter
  // ---------------------------------------------------------------------------
`ifdef LSF_SCHED_HITCNT_EN
  logic [15:0] r_hit_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hit_cnt <= '0;
    end else if (w_accept && (r_hit_cnt != 16'hFFFF)) begin
      r_hit_cnt <= r_hit_cnt + 16'd1;
    end
  end

  assign hit_count = r_hit_cnt;
`endif

endmodule

// File: tb/tb_lsf_theta_scheduler.sv
// -----------------------------------------------------------------------------
// tb_lsf_theta_scheduler
//
// Directed bench for lsf_theta_scheduler with NTHETA=4, W_THETA=2, LUT_LAT=1.
// Cycle n is the clock period that follows the nth rising edge after the
// stimulus starts; inputs change 1 ns after a rising edge and outputs are
// sampled on the falling edge. Each vec() call applies one cycle of stimulus
// and compares every output against hand-derived values.
// -----------------------------------------------------------------------------
module tb_lsf_theta_scheduler;

  localparam int NTHETA  = 4;
  localparam int W_THETA = 2;
  localparam int W_X     = 14;
  localparam int W_Y     = 14;
  localparam int W_r     = 22;
  localparam int LUT_LAT = 1;

  logic               clk;
  logic               rst_n;
  logic               in_vld;
  logic               in_ready;
  logic [W_X-1:0]     in_localx;
  logic [W_Y-1:0]     in_localy;
  logic [W_r-1:0]     in_r_offset;
  logic               stall;
  logic [W_THETA-1:0] lut_addr;
  logic               dp_hit_vld;
  logic [W_X-1:0]     dp_localx;
  logic [W_Y-1:0]     dp_localy;
  logic [W_r-1:0]     dp_r_offset;
  logic [W_THETA-1:0] theta_tag;
  logic               busy;
  logic               sweep_done;
`ifdef LSF_SCHED_HITCNT_EN
  logic [15:0]        hit_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  lsf_theta_scheduler #(
    .NTHETA (NTHETA),
    .W_THETA(W_THETA),
    .W_X    (W_X),
    .W_Y    (W_Y),
    .W_r    (W_r),
    .LUT_LAT(LUT_LAT)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_vld     (in_vld),
    .in_ready   (in_ready),
    .in_localx  (in_localx),
    .in_localy  (in_localy),
    .in_r_offset(in_r_offset),
    .stall      (stall),
    .lut_addr   (lut_addr),
    .dp_hit_vld (dp_hit_vld),
    .dp_localx  (dp_localx),
    .dp_localy  (dp_localy),
    .dp_r_offset(dp_r_offset),
    .theta_tag  (theta_tag),
    .busy       (busy),
`ifdef LSF_SCHED_HITCNT_EN
    .hit_count  (hit_count),
`endif
    .sweep_done (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_hit(input int x, input int y, input int r);
    in_localx   = W_X'(x);
    in_localy   = W_Y'(y);
    in_r_offset = W_r'(r);
  endtask

  // One cycle: drive vld/stall/rst_n, sample on the falling edge, compare all
  // outputs, then advance to 1 ns past the next rising edge.
  task automatic vec(input string name, input logic vld, input logic stl, input logic rstn,
                     input logic e_rdy, input int e_addr, input logic e_dv,
                     input int e_x, input int e_y, input int e_r,
                     input logic e_done, input logic e_busy, input int e_tag);
    in_vld = vld;
    stall  = stl;
    rst_n  = rstn;
    @(negedge clk);
    check({name, " in_ready"},    32'(in_ready),    32'(e_rdy));
    check({name, " lut_addr"},    32'(lut_addr),    32'(e_addr));
    check({name, " dp_hit_vld"},  32'(dp_hit_vld),  32'(e_dv));
    check({name, " dp_localx"},   32'(dp_localx),   32'(e_x));
    check({name, " dp_localy"},   32'(dp_localy),   32'(e_y));
    check({name, " dp_r_offset"}, 32'(dp_r_offset), 32'(e_r));
    check({name, " sweep_done"},  32'(sweep_done),  32'(e_done));
    check({name, " busy"},        32'(busy),        32'(e_busy));
    check({name, " theta_tag"},   32'(theta_tag),   32'(e_tag));
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    in_vld = 1'b0;
    stall  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    in_vld = 1'b0;
    stall  = 1'b0;
    set_hit(0, 0, 0);
    @(posedge clk);
    #1;

    //   name      vld stl rst rdy addr dv x  y  r   done busy tag
    vec("reset",   0,  0,  0,  0,  0,   0, 0, 0, 0,   0,   0,   0);
    vec("reset2",  0,  0,  0,  0,  0,   0, 0, 0, 0,   0,   0,   0);

    // Single hit: lut_addr 0..3 at c1-4, dp valid c2-5, done c4, tag 0..3 c4-7.
    set_hit(5, 3, 100);
    vec("t1 c0",   1,  0,  1,  1,  0,   0, 0, 0, 0,   0,   0,   0);
    vec("t1 c1",   0,  0,  1,  0,  0,   0, 0, 0, 0,   0,   1,   0);
    vec("t1 c2",   0,  0,  1,  0,  1,   1, 5, 3, 100, 0,   1,   0);
    vec("t1 c3",   0,  0,  1,  0,  2,   1, 5, 3, 100, 0,   1,   0);
    vec("t1 c4",   0,  0,  1,  1,  3,   1, 5, 3, 100, 1,   1,   0);
    vec("t1 c5",   0,  0,  1,  1,  0,   1, 5, 3, 100, 0,   1,   1);
    vec("t1 c6",   0,  0,  1,  1,  0,   0, 0, 0, 0,   0,   1,   2);
    vec("t1 c7",   0,  0,  1,  1,  0,   0, 0, 0, 0,   0,   1,   3);
    vec("t1 c8",   0,  0,  1,  1,  0,   0, 0, 0, 0,   0,   0,   0);
`ifdef LSF_SCHED_HITCNT_EN
    check("t1 hit_count", 32'(hit_count), 32'd1);
`endif
    idle_cycles(3);

    // Two hits back to back: second accepted at c4, dp valid c2..c9.
    set_hit(1, 2, 3);
    vec("t2 c0",   1,  0,  1,  1,  0,   0, 0, 0, 0,   0,   0,   0);
    set_hit(7, 8, 9);
    vec("t2 c1",   1,  0,  1,  0,  0,   0, 0, 0, 0,   0,   1,   0);
    vec("t2 c2",   1,  0,  1,  0,  1,   1, 1, 2, 3,   0,   1,   0);
    vec("t2 c3",   1,  0,  1,  0,  2,   1, 1, 2, 3,   0,   1,   0);
    vec("t2 c4",   1,  0,  1,  1,  3,   1, 1, 2, 3,   1,   1,   0);
    vec("t2 c5",   0,  0,  1,  0,  0,   1, 1, 2, 3,   0,   1,   1);
    vec("t2 c6",   0,  0,  1,  0,  1,   1, 7, 8, 9,   0,   1,   2);
    vec("t2 c7",   0,  0,  1,  0,  2,   1, 7, 8, 9,   0,   1,   3);
    vec("t2 c8",   0,  0,  1,  1,  3,   1, 7, 8, 9,   1,   1,   0);
    vec("t2 c9",   0,  0,  1,  1,  0,   1, 7, 8, 9,   0,   1,   1);
    vec("t2 c10",  0,  0,  1,  1,  0,   0, 0, 0, 0,   0,   1,   2);
    vec("t2 c11",  0,  0,  1,  1,  0,   0, 0, 0, 0,   0,   1,   3);
    vec("t2 c12",  0,  0,  1,  1,  0,   0, 0, 0, 0,   0,   0,   0);
    idle_cycles(3);

    // Stall at c2-3: lut_addr holds 1 through c4, dp gap at c3-4, done at c6.
    set_hit(4, 11, 2000);
    vec("t3 c0",   1,  0,  1,  1,  0,   0, 0, 0, 0,    0,  0,   0);
    vec("t3 c1",   0,  0,  1,  0,  0,   0, 0, 0, 0,    0,  1,   0);
    vec("t3 c2",   0,  1,  1,  0,  1,   1, 4, 11, 2000, 0, 1,   0);
    vec("t3 c3",   0,  1,  1,  0,  1,   0, 0, 0, 0,    0,  1,   0);
    vec("t3 c4",   0,  0,  1,  0,  1,   0, 0, 0, 0,    0,  1,   0);
    vec("t3 c5",   0,  0,  1,  0,  2,   1, 4, 11, 2000, 0, 1,   1);
    vec("t3 c6",   0,  0,  1,  1,  3,   1, 4, 11, 2000, 1, 1,   1);
    vec("t3 c7",   0,  0,  1,  1,  0,   1, 4, 11, 2000, 0, 1,   1);
    vec("t3 c8",   0,  0,  1,  1,  0,   0, 0, 0, 0,    0,  1,   2);
    vec("t3 c9",   0,  0,  1,  1,  0,   0, 0, 0, 0,    0,  1,   3);
    vec("t3 c10",  0,  0,  1,  1,  0,   0, 0, 0, 0,    0,  0,   0);
    idle_cycles(3);

    // Reset mid-sweep at c2 (held through c3): everything clears, no more
    // datapath valids, in_ready returns at c4.
    set_hit(6, 6, 6);
    vec("t4 c0",   1,  0,  1,  1,  0,   0, 0, 0, 0,   0,   0,   0);
    vec("t4 c1",   0,  0,  1,  0,  0,   0, 0, 0, 0,   0,   1,   0);
    vec("t4 c2",   0,  0,  0,  0,  1,   1, 6, 6, 6,   0,   1,   0);
    vec("t4 c3",   0,  0,  0,  0,  0,   0, 0, 0, 0,   0,   0,   0);
    vec("t4 c4",   0,  0,  1,  1,  0,   0, 0, 0, 0,   0,   0,   0);
    vec("t4 c5",   0,  0,  1,  1,  0,   0, 0, 0, 0,   0,   0,   0);
    vec("t4 c6",   0,  0,  1,  1,  0,   0, 0, 0, 0,   0,   0,   0);
    vec("t4 c7",   0,  0,  1,  1,  0,   0, 0, 0, 0,   0,   0,   0);

`ifdef LSF_SCHED_HITCNT_EN
    // Counter was cleared by the reset above; accept three fresh hits.
    check("t5 hit_count after reset", 32'(hit_count), 32'd0);
    for (int h = 0; h < 3; h++) begin
      set_hit(h + 1, h + 1, h + 1);
      in_vld = 1'b1;
      @(posedge clk);
      #1;
      in_vld = 1'b0;
      idle_cycles(NTHETA + 4);
    end
    check("t5 hit_count", 32'(hit_count), 32'd3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t5 hit_count cleared", 32'(hit_count), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsf_theta_scheduler.md
LSF_THETA_SCHEDULER -- requirements
Module: lsf_theta_scheduler

Interface
REQ-001 SHALL have parameter NTHETA, default 128: theta bins swept per hit (power of 2, 4 to 256).
REQ-002 SHALL have parameter W_THETA, default 7: width of theta index, equal to log2(NTHETA).
REQ-003 SHALL have parameter W_X, default 14, and W_Y, default 14: widths of hit local x and y.
REQ-004 SHALL have parameter W_r, default 22: width of r offset.
REQ-005 SHALL have parameter LUT_LAT, default 1: sin/cos LUT read latency in cycles (0 to 3).
REQ-006 SHALL have ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
in_vld  in  1  input hit valid
in_ready  out  1  hit accepted when in_vld and in_ready are both high
in_localx  in  W_X  hit local x
in_localy  in  W_Y  hit local y
in_r_offset  in  W_r  hit r offset
stall  in  1  downstream histogram backpressure; freezes sweep
lut_addr  out  W_THETA  sin/cos LUT address (theta index)
dp_hit_vld  out  1  r-bin datapath hit valid, aligned with LUT data
dp_localx  out  W_X  datapath x, aligned with dp_hit_vld
dp_localy  out  W_Y  datapath y, aligned with dp_hit_vld
dp_r_offset  out  W_r  datapath r offset, aligned with dp_hit_vld
theta_tag  out  W_THETA  theta index aligned with datapath r_bin output
busy  out  1  sweep in progress or pipeline not empty
sweep_done  out  1  one-cycle pulse when the last theta of a hit is issued

Function
REQ-007 SHALL implement states IDLE and SWEEP.
REQ-008 IDLE: in_ready=1; on acceptance, SHALL capture x, y and r_offset, set theta counter to 0, and enter SWEEP.
REQ-009 SWEEP, stall=0: SHALL issue one theta per cycle (lut_addr = counter, internal issue strobe = 1), with the counter incrementing 0 to NTHETA-1.
REQ-010 SWEEP, stall=1: SHALL hold the counter and drive issue strobe 0; in_ready=0.
REQ-011 On the last theta (counter = NTHETA-1, stall=0), SHALL pulse sweep_done and drive in_ready=1; if a hit is accepted that cycle, SHALL reload, reset the counter to 0 and stay in SWEEP (back-to-back, no bubble); otherwise SHALL return to IDLE.
REQ-012 in_ready SHALL be 0 in all other SWEEP cycles.
REQ-013 dp_hit_vld and dp_localx/y/r_offset SHALL be the issue strobe and captured hit delayed by exactly LUT_LAT cycles (LUT_LAT=0: combinationally equal).
REQ-014 theta_tag SHALL equal lut_addr delayed by LUT_LAT+2 cycles, matching the 2-cycle r-bin datapath.
REQ-015 dp_* data SHALL read 0 when dp_hit_vld=0.
REQ-016 busy SHALL be 1 in SWEEP and while any issue strobe remains in the LUT_LAT+2 delay line.
REQ-017 Throughput SHALL be one hit per NTHETA cycles with no stall.

Reset
REQ-018 rst_n=0 SHALL force IDLE, counter 0, all delay lines cleared; outputs in_ready=0, dp_hit_vld=0, sweep_done=0, busy=0, lut_addr=0, theta_tag=0, dp_* = 0.
REQ-019 Reset mid-sweep SHALL abort the hit with no further dp_hit_vld; in_ready SHALL rise in the first cycle after rst_n returns high.

Configuration
REQ-020 Macro LSF_SCHED_HITCNT_EN defined: SHALL add output hit_count (16 bits), incremented on each accepted hit, saturating at 0xFFFF, cleared by reset.
REQ-021 Macro absent: hit_count port and counter SHALL not exist; all other behaviour is identical.

Verification (NTHETA=4, W_THETA=2, LUT_LAT=1)
REQ-022 Single hit x=5, y=3, r=100 accepted at cycle 0 -> lut_addr 0,1,2,3 at cycles 1-4; dp_hit_vld high at cycles 2-5 carrying 5/3/100; sweep_done at cycle 4; theta_tag 0..3 at cycles 4-7; busy falls after cycle 7.
REQ-023 in_vld held high with two hits -> second hit accepted at cycle 4; lut_addr 0 at cycle 5; dp_hit_vld continuous for 8 cycles.
REQ-024 stall=1 at cycles 2-3 of a sweep -> lut_addr holds 1; dp_hit_vld low at cycles 3-4; sweep_done delayed to cycle 6; theta sequence still 0,1,2,3 with no repeats.
REQ-025 rst_n=0 at cycle 2 of a sweep -> all outputs 0 next cycle; no dp_hit_vld after reset; in_ready=1 in the first cycle after release.
REQ-026 With LSF_SCHED_HITCNT_EN defined, 3 accepted hits -> hit_count=3; reset -> 0.
